// File: rtl/vga_sync_decoder.sv
`default_nettype none
// ============================================================================
// Module   : vga_sync_decoder
// Brief    : Rebuilds column/row counters, active-video flag and a lock
//            indicator from active-low H/V sync pulses of a raster stream.
//            Counters free-run on prediction and realign on falling sync
//            edges; a SEARCH/VERIFY/LOCKED machine qualifies the timing.
// Revision : 1.0 - initial release
// ============================================================================
module vga_sync_decoder #(
    parameter int TOTAL_COLS  = 800,
    parameter int TOTAL_ROWS  = 525,
    parameter int ACTIVE_COLS = 640,
    parameter int ACTIVE_ROWS = 480,
    parameter int H_FRONT     = 18,
    parameter int V_FRONT     = 10,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       CLK,
    input  logic       i_Rst_L,
    input  logic       i_H_Sync,
    input  logic       i_V_Sync,
    output logic [9:0] o_Col_Count,
    output logic [9:0] o_Row_Count,
    output logic       o_Active,
    output logic       o_Frame_Start,
    output logic       o_Locked
);

    localparam logic [9:0] c_H_SYNC_COL   = 10'(ACTIVE_COLS + H_FRONT);
    localparam logic [9:0] c_V_SYNC_ROW   = 10'(ACTIVE_ROWS + V_FRONT);
    localparam logic [9:0] c_LAST_COL     = 10'(TOTAL_COLS - 1);
    localparam logic [9:0] c_LAST_ROW     = 10'(TOTAL_ROWS - 1);
    localparam logic [9:0] c_ACTIVE_COLS  = 10'(ACTIVE_COLS);
    localparam logic [9:0] c_ACTIVE_ROWS  = 10'(ACTIVE_ROWS);
    localparam logic [2:0] c_LOCK_FRAMES  = 3'(LOCK_FRAMES);

    localparam logic [1:0] c_SEARCH = 2'd0;
    localparam logic [1:0] c_VERIFY = 2'd1;
    localparam logic [1:0] c_LOCKED = 2'd2;

    logic       r_h_prev;
    logic       r_v_prev;
    logic [9:0] r_col;
    logic [9:0] r_row;
    logic [1:0] r_state;
    logic [2:0] r_good;
    logic       r_v_seen;
    logic       r_active;
    logic       r_frame_start;
    logic       r_locked;

    logic       w_h_edge;
    logic       w_v_edge;
    logic [9:0] w_pc;
    logic [9:0] w_pr;
    logic [9:0] w_col_next;
    logic [9:0] w_row_next;
    logic       w_h_mis;
    logic       w_v_mis;
    logic [1:0] w_state_next;
    logic [2:0] w_good_next;
    logic [2:0] w_good_inc;
    logic       w_lock_next;

    // Predicted position, realigned position and sync-timing mismatches
    always_comb begin
        w_h_edge   = r_h_prev & ~i_H_Sync;
        w_v_edge   = r_v_prev & ~i_V_Sync;
        w_pc       = (r_col == c_LAST_COL) ? 10'd0 : r_col + 10'd1;
        w_pr       = r_row;
        if (w_pc == 10'd0) begin
            w_pr = (r_row == c_LAST_ROW) ? 10'd0 : r_row + 10'd1;
        end
        w_col_next = w_h_edge ? c_H_SYNC_COL : w_pc;
        w_row_next = w_v_edge ? c_V_SYNC_ROW : w_pr;
        w_h_mis    = w_h_edge ? (w_pc != c_H_SYNC_COL) : (w_pc == c_H_SYNC_COL);
        // Leaving the sync row without having seen its V edge is a miss too
        w_v_mis    = (w_v_edge && (w_pr != c_V_SYNC_ROW)) ||
                     ((r_row == c_V_SYNC_ROW) && (w_pr != c_V_SYNC_ROW) && !r_v_seen);
    end

    // Lock qualification: SEARCH -> VERIFY on any V edge, LOCKED after enough good frames
    always_comb begin
        w_state_next = r_state;
        w_good_next  = r_good;
        w_good_inc   = r_good + 3'd1;
        case (r_state)
            c_SEARCH: begin
                if (w_v_edge) begin
                    w_state_next = c_VERIFY;
                    w_good_next  = 3'd0;
                end
            end
            c_VERIFY: begin
                if (w_h_mis || w_v_mis) begin
                    w_state_next = c_SEARCH;
                end else if (w_v_edge) begin
                    w_good_next = w_good_inc;
                    if (w_good_inc == c_LOCK_FRAMES) begin
                        w_state_next = c_LOCKED;
                    end
                end
            end
            c_LOCKED: begin
                if (w_h_mis || w_v_mis) begin
                    w_state_next = c_SEARCH;
                end
            end
            default: w_state_next = c_SEARCH;
        endcase
        w_lock_next = (w_state_next == c_LOCKED);
    end

    // Sync history for falling-edge detection; idles at the inactive level
    always_ff @(posedge CLK or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_h_prev <= 1'b1;
            r_v_prev <= 1'b1;
        end else begin
            r_h_prev <= i_H_Sync;
            r_v_prev <= i_V_Sync;
        end
    end

    // Column/row counters, always realigned on edges regardless of lock state
    always_ff @(posedge CLK or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_col <= 10'd0;
            r_row <= 10'd0;
        end else begin
            r_col <= w_col_next;
            r_row <= w_row_next;
        end
    end

    // V-edge-seen flag: set by a V edge, cleared when the counters enter the sync row
    always_ff @(posedge CLK or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_v_seen <= 1'b0;
        end else if (w_v_edge) begin
            r_v_seen <= 1'b1;
        end else if ((w_row_next == c_V_SYNC_ROW) && (r_row != c_V_SYNC_ROW)) begin
            r_v_seen <= 1'b0;
        end
    end

    // Lock state machine and good-frame counter
    always_ff @(posedge CLK or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_state <= c_SEARCH;
            r_good  <= 3'd0;
        end else begin
            r_state <= w_state_next;
            r_good  <= w_good_next;
        end
    end

    // Status outputs from next-count values so they line up with the counters
    always_ff @(posedge CLK or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_locked      <= 1'b0;
            r_active      <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_locked      <= w_lock_next;
            r_active      <= w_lock_next && (w_col_next < c_ACTIVE_COLS) &&
                             (w_row_next < c_ACTIVE_ROWS);
            r_frame_start <= w_lock_next && (w_col_next == 10'd0) && (w_row_next == 10'd0);
        end
    end

    assign o_Col_Count   = r_col;
    assign o_Row_Count   = r_row;
    assign o_Active      = r_active;
    assign o_Frame_Start = r_frame_start;
    assign o_Locked      = r_locked;

endmodule
`default_nettype wire

// File: doc/vga_sync_decoder.md
Name: vga_sync_decoder

Overview:
- Receive-side counterpart to the sync/porch generator. Takes active-low H/V sync pulses from the 800x525 timing chain and rebuilds column/row counters, the active-video flag and a lock indicator.
- Used by downstream pixel consumers (pattern checkers, overlay, capture) that see only sync signals.
- Runs in the pixel clock domain; inputs are already synchronous to CLK.

Parameters:
- TOTAL_COLS, 800, pixels per line (≤1024)
- TOTAL_ROWS, 525, lines per frame (≤1024)
- ACTIVE_COLS, 640, visible columns
- ACTIVE_ROWS, 480, visible rows
- H_FRONT, 18, horizontal front porch; H sync falls at column ACTIVE_COLS+H_FRONT (H_SYNC_COL=658)
- V_FRONT, 10, vertical front porch; V sync falls in row ACTIVE_ROWS+V_FRONT (V_SYNC_ROW=490)
- LOCK_FRAMES, 2, consecutive matching V edges in VERIFY needed to lock (1..7)

Ports:
- CLK  in  1  pixel clock, all logic on rising edge
- i_Rst_L  in  1  reset, asynchronous assert, active-low
- i_H_Sync  in  1  horizontal sync, active-low, idles high
- i_V_Sync  in  1  vertical sync, active-low, idles high
- o_Col_Count  out  10  recovered column, 0..TOTAL_COLS-1
- o_Row_Count  out  10  recovered row, 0..TOTAL_ROWS-1
- o_Active  out  1  high when locked, col<ACTIVE_COLS and row<ACTIVE_ROWS
- o_Frame_Start  out  1  one-cycle pulse when counters enter (0,0) while locked
- o_Locked  out  1  decoder locked to incoming timing

Behaviour:
- Reset (i_Rst_L=0, async):
  - All outputs 0; internal counts 0.
  - Edge-detect history registers set to 1 (idle level).
  - State SEARCH; good-frame counter 0.
- Edge detect:
  - H edge = i_H_Sync==0 and previous sample==1. V edge likewise.
  - Only falling edges matter; rising edges are ignored.
- Column counter:
  - Prediction P_c = (col==TOTAL_COLS-1) ? 0 : col+1.
  - Next col = H_SYNC_COL on an H edge, else P_c.
  - Latency: o_Col_Count==658 on the cycle after the edge is sampled.
- Row counter:
  - Prediction P_r = row+1 (wrap TOTAL_ROWS-1→0) when P_c==0, else row.
  - Next row = V_SYNC_ROW on a V edge, else P_r.
  - A V edge overrides a simultaneous column wrap: row=490. The column still follows its own rule.
- Mismatch detection:
  - H mismatch = (H edge and P_c≠H_SYNC_COL) or (no H edge and P_c==H_SYNC_COL).
  - V mismatch = (V edge and P_r≠V_SYNC_ROW) or (row==V_SYNC_ROW, P_r≠V_SYNC_ROW, and no V edge seen while in row 490). A one-bit flag is cleared on entry to row 490 and set by a V edge.
- State machine (2 bits):
  - SEARCH: counters realign on edges; mismatches ignored. A V edge moves to VERIFY with good-frame counter 0.
  - VERIFY: any H or V mismatch moves to SEARCH. Each matching V edge increments the counter; reaching LOCK_FRAMES moves to LOCKED.
  - LOCKED: any mismatch moves to SEARCH the following cycle. Counters still realign on the offending edge.
- Outputs:
  - o_Locked = (state==LOCKED), registered.
  - o_Active and o_Frame_Start are registered, computed from next-count values so they align with o_Col_Count/o_Row_Count.
  - Both are forced to 0 when not locked.
- Reset released mid-frame: restart in SEARCH. Output is undefined only in the sense that counts may be misaligned; o_Locked and o_Active stay 0 until relocked.

Test Plan:
- Reset, then a clean 800x525 stream (H sync at col 658 for 92 cycles, V sync at row 490 for 2 lines) → o_Locked=0 through the 2nd V edge and rises 1 cycle after the 3rd V edge (LOCK_FRAMES=2).
- Locked, one full frame → o_Col_Count==658 one cycle after each H edge; o_Frame_Start exactly once per 420000 cycles with col=0,row=0; o_Active high 307200 cycles per frame.
- Locked, H edge on line 100 arrives 1 cycle early → o_Locked=0 next cycle; o_Col_Count=658 after that edge; relock after 3 further V edges.
- Locked, one H pulse suppressed → o_Locked falls on the cycle P_c==658; o_Active stays 0 until relock.
- Locked, i_Rst_L pulsed low mid-line 200 → all outputs 0 immediately (no clock edge needed); relock needs 3 V edges.
- V edge coincident with the column wrap (P_c==0) → next cycle o_Row_Count=490, o_Col_Count=0, no V mismatch reported.
